// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg -- shared definitions for the round-robin bus router.
//
// Contents:
//   ID_W          width of the destination-ID field at the top of a packet
//   MAX_PKT_W     widest packet get_dest_id() accepts
//   bus_state_e   router FSM state encoding (IDLE / GRANT / DELIVER)
//   get_dest_id() returns the top ID_W bits of a pkt_w-bit packet
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int ID_W      = 8;
  localparam int MAX_PKT_W = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_DELIVER = 2'd2
  } bus_state_e;

  // The packet arrives zero-extended to MAX_PKT_W bits. Shifting right by
  // (pkt_w - ID_W) brings the ID field down to bit 0.
  function automatic logic [ID_W-1:0] get_dest_id(
    input logic [MAX_PKT_W-1:0] pkt,
    input int                   pkt_w
  );
    logic [MAX_PKT_W-1:0] sh;
    sh = pkt >> (pkt_w - ID_W);
    return sh[ID_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter -- combinational round-robin selector.
//
// Picks the requester nearest at or after ptr_i, wrapping modulo N.
//
// Ports:
//   req_i    [N-1:0]   request vector
//   ptr_i    [PW-1:0]  highest-priority index (always < N)
//   grant_o  [PW-1:0]  index of the chosen requester (0 when none)
//   valid_o            at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] grant_o,
  output logic          valid_o
);

  // For each requester, compute its forward distance from the pointer.
  // The requester with the smallest distance wins.
  always_comb begin
    int p;
    int d;
    int best;
    grant_o = '0;
    valid_o = 1'b0;
    p       = int'(ptr_i);
    d       = 0;
    best    = N;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        d = (i >= p) ? (i - p) : (i + N - p);
        if (d < best) begin
          best    = d;
          grant_o = PW'(i);
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_rr_router.sv
// -----------------------------------------------------------------------------
// bus_rr_router -- round-robin packet router between drvrs devices.
//
// Each device offers a head packet (pndng/D_pop). The router grants one
// device, pops its packet, and delivers it. A packet goes either to a single
// destination or, when its ID equals `broadcast`, to every other device.
// Packets that cannot be delivered are dropped.
//
// Handshake semantics: pop[i] and push[i] are single-cycle pulses. A device
// dequeues its head packet in any cycle where pop[i] is high. A device writes
// D_push[i] in any cycle where push[i] is high. The router never pushes to a
// target whose full bit is high in that cycle. Instead it waits in DELIVER
// until every target can accept, then pushes to all targets at once.
//
// Ports:
//   clk, reset          rising-edge clock; synchronous active-low reset
//   pndng   [drvrs]     device i has a packet ready
//   D_pop   [drvrs][W]  head packet of device i
//   full    [drvrs]     device i cannot accept a packet
//   pop     [drvrs]     dequeue pulse to device i
//   push    [drvrs]     write pulse to device i
//   D_push  [drvrs][W]  packet register, copied to every device
//   drop                granted packet discarded (bad or self destination)
//   busy                FSM not in IDLE
//   dbg_state [2]       current FSM state (bus_state_e encoding)
//   pkt_cnt, drop_cnt   saturating counters; present only with BUS_STATS_EN
//
// Optional feature macro: BUS_STATS_EN
// -----------------------------------------------------------------------------
module bus_rr_router
  import bus_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]                full,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
  output logic                            drop,
  output logic                            busy,
  output logic [1:0]                      dbg_state
`ifdef BUS_STATS_EN
  ,
  output logic [31:0]                     pkt_cnt,
  output logic [31:0]                     drop_cnt
`endif
);

  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

  // Parameter legality, checked at elaboration.
  if (bits != 1) begin : g_bad_bits
    $error("bus_rr_router: only bits=1 is supported");
  end
  if (drvrs < 1 || drvrs > 255) begin : g_bad_drvrs
    $error("bus_rr_router: drvrs must be in 1..255");
  end
  if (pckg_sz < 9 || pckg_sz > MAX_PKT_W) begin : g_bad_pckg_sz
    $error("bus_rr_router: pckg_sz out of range");
  end

  bus_state_e           state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        src_q, src_d;
  logic [pckg_sz-1:0]   pkt_q, pkt_d;

  logic [PW-1:0]        arb_grant;
  logic                 arb_valid;
  logic [ID_W-1:0]      dest_id;
  logic [drvrs-1:0]     targets;

  rr_arbiter #(
    .N  (drvrs),
    .PW (PW)
  ) u_arb (
    .req_i   (pndng),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  assign dest_id = get_dest_id(MAX_PKT_W'(pkt_q), pckg_sz);

  // Target set for the packet in pkt_q. Out-of-range IDs match no lane, and
  // the source lane is always excluded, so an empty set covers bad IDs,
  // self-addressed unicasts, and broadcast with a single device.
  always_comb begin
    targets = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (dest_id == broadcast) begin
        targets[i] = (32'(src_q) != i);
      end else begin
        targets[i] = (32'(dest_id) == i) && (32'(src_q) != i);
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    pkt_d    = pkt_q;
    pop      = '0;
    push     = '0;
    drop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          src_d   = arb_grant;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        for (int i = 0; i < drvrs; i++) begin
          if (32'(src_q) == i) begin
            pop[i] = 1'b1;
            pkt_d  = D_pop[i];
          end
        end
        rr_ptr_d = (32'(src_q) == drvrs - 1) ? '0 : src_q + PW'(1);
        state_d  = ST_DELIVER;
      end
      ST_DELIVER: begin
        if (targets == '0) begin
          drop    = 1'b1;
          state_d = ST_IDLE;
        end else if ((full & targets) == '0) begin
          push    = targets;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      src_q    <= '0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      pkt_q    <= pkt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    for (int i = 0; i < drvrs; i++) begin
      D_push[i] = pkt_q;
    end
  end

`ifdef BUS_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] drop_cnt_q;

  // A broadcast counts once, because all targets are pushed in one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if ((|push) && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bus_rr_router.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_router -- directed testbench for bus_rr_router (drvrs=4,
// pckg_sz=16, broadcast=8'hFF).
//
// A transaction-level model tracks the packet in flight. A negedge process
// compares every DUT output against it on every cycle. Directed sections
// add literal expectations worked out by hand.
// -----------------------------------------------------------------------------
module tb_bus_rr_router;

  localparam int N = 4;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [N-1:0]        pndng = '0;
  logic [N-1:0]        full = '0;
  logic [N-1:0][W-1:0] D_pop;
  logic [N-1:0]        pop;
  logic [N-1:0]        push;
  logic [N-1:0][W-1:0] D_push;
  logic                drop;
  logic                busy;
  logic [1:0]          dbg_state;
`ifdef BUS_STATS_EN
  logic [31:0]         pkt_cnt;
  logic [31:0]         drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  bus_rr_router #(
    .bits      (1),
    .drvrs     (N),
    .pckg_sz   (W),
    .broadcast (8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pndng     (pndng),
    .D_pop     (D_pop),
    .full      (full),
    .pop       (pop),
    .push      (push),
    .D_push    (D_push),
    .drop      (drop),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef BUS_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------- model
  // At most one packet is in flight. Phase 1 is the dequeue cycle and
  // phase 2 is the delivery attempt.
  bit              m_active = 1'b0;
  int              m_phase = 0;
  int              m_src = 0;
  int              m_rr = 0;
  logic [W-1:0]    m_pkt = '0;
  int              m_pkt_cnt = 0;
  int              m_drop_cnt = 0;

  function automatic logic [N-1:0] m_targets();
    logic [N-1:0] t;
    int id;
    t  = '0;
    id = int'(m_pkt[15:8]);
    if (id == 255) begin
      for (int i = 0; i < N; i++) if (i != m_src) t[i] = 1'b1;
    end else if (id < N && id != m_src) begin
      t[id] = 1'b1;
    end
    return t;
  endfunction

  always @(posedge clk) begin : model_blk
    logic [N-1:0] t;
    bit found;
    int j;
    if (!reset) begin
      m_active = 1'b0; m_phase = 0; m_src = 0; m_rr = 0; m_pkt = '0;
      m_pkt_cnt = 0; m_drop_cnt = 0;
    end else if (!m_active) begin
      if (pndng != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (!found && pndng[j]) begin
            m_src = j;
            found = 1'b1;
          end
        end
        m_active = 1'b1;
        m_phase  = 1;
      end
    end else if (m_phase == 1) begin
      m_pkt   = D_pop[m_src];
      m_rr    = (m_src + 1) % N;
      m_phase = 2;
    end else begin
      t = m_targets();
      if (t == '0) begin
        m_drop_cnt++;
        m_active = 1'b0;
      end else if ((full & t) == '0) begin
        m_pkt_cnt++;
        m_active = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin : cmp_blk
    logic [N-1:0] t;
    logic [N-1:0] exp_pop;
    logic [N-1:0] exp_push;
    logic         exp_drop;
    if (chk_en) begin
      t        = m_targets();
      exp_pop  = (m_active && m_phase == 1) ? (4'b0001 << m_src) : 4'b0000;
      exp_push = (m_active && m_phase == 2 && t != '0 && (full & t) == '0) ? t : 4'b0000;
      exp_drop = m_active && m_phase == 2 && t == '0;
      check("pop", pop, exp_pop);
      check("push", push, exp_push);
      check("drop", drop, exp_drop);
      check("busy", busy, m_active);
      for (int i = 0; i < N; i++) check($sformatf("d_push%0d", i), D_push[i], m_pkt);
      check("pop_onehot", ($countones(pop) <= 1), 1'b1);
      check("pop_push_excl", ((|pop) && (|push)), 1'b0);
`ifdef BUS_STATS_EN
      check("pkt_cnt", pkt_cnt, m_pkt_cnt);
      check("drop_cnt", drop_cnt, m_drop_cnt);
`endif
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Offer one packet. Returns at the start of the cycle after the pop.
  task automatic send(input int src, input logic [W-1:0] pkt, input logic [N-1:0] fl);
    bit ok;
    ok         = 1'b0;
    D_pop[src] = pkt;
    pndng[src] = 1'b1;
    full       = fl;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (pop[src]) ok = 1'b1;
    end
    if (!ok) timeout_fail($sformatf("pop_wait_dev%0d", src));
    tick();
    pndng[src] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) timeout_fail("idle_wait");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- tests
  initial begin
    int order[5];
    int when[5];
    int n_pop;
    int cyc;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) D_pop[i] = '0;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_pop", pop, 4'b0000);
    check("rst_push", push, 4'b0000);
    check("rst_drop", drop, 1'b0);
    check("rst_dpush", D_push[0], 16'h0000);
    tick();
    reset = 1'b1;

    // full toggling while idle has no effect
    full = 4'b1111;
    tick();
    full = 4'b0000;
    tick();

    // Unicast latency: device 1 -> device 2
    D_pop[1] = 16'h02AB;
    pndng    = 4'b0010;
    @(negedge clk);
    check("t034_idle_busy", busy, 1'b0);
    @(negedge clk);
    check("t034_pop", pop, 4'b0010);
    tick();
    pndng = 4'b0000;
    @(negedge clk);
    check("t034_push", push, 4'b0100);
    check("t034_dpush", D_push[2], 16'h02AB);
    tick();
    wait_idle();

    // Round-robin order with all devices requesting
    do_reset();
    for (int i = 0; i < N; i++) D_pop[i] = {8'((i + 1) % N), 8'(16 * i)};
    pndng = 4'b1111;
    n_pop = 0;
    cyc   = 0;
    for (int k = 0; k < 40 && n_pop < 5; k++) begin
      @(negedge clk);
      cyc++;
      if (pop != '0) begin
        for (int i = 0; i < N; i++) if (pop[i]) order[n_pop] = i;
        when[n_pop] = cyc;
        n_pop++;
      end
    end
    if (n_pop < 5) timeout_fail("t035_pops");
    tick();
    pndng = 4'b0000;
    for (int k = 0; k < n_pop; k++) begin
      check($sformatf("t035_order%0d", k), order[k], exp_order[k]);
      if (k > 0) check($sformatf("t035_gap%0d", k), when[k] - when[k-1], 3);
    end
    wait_idle();

    // Broadcast from device 0
    do_reset();
    send(0, 16'hFF55, 4'b0000);
    @(negedge clk);
    check("t036_push", push, 4'b1110);
    check("t036_dpush3", D_push[3], 16'hFF55);
    tick();
    @(negedge clk);
    check("t036_push_once", push, 4'b0000);
`ifdef BUS_STATS_EN
    check("t036_pkt_cnt", pkt_cnt, 32'd1);
`endif
    tick();

    // Drops: out-of-range ID, then a self-addressed unicast
    do_reset();
    send(2, 16'h0711, 4'b0000);
    @(negedge clk);
    check("t037_drop_a", drop, 1'b1);
    check("t037_nopush_a", push, 4'b0000);
    tick();
    send(2, 16'h0233, 4'b0000);
    @(negedge clk);
    check("t037_drop_b", drop, 1'b1);
    check("t037_nopush_b", push, 4'b0000);
    tick();
    @(negedge clk);
    check("t037_drop_once", drop, 1'b0);
`ifdef BUS_STATS_EN
    check("t037_drop_cnt", drop_cnt, 32'd2);
    check("t037_pkt_cnt", pkt_cnt, 32'd0);
`endif
    tick();

    // Stall on a full target
    send(3, 16'h0199, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t038_stall_push%0d", k), push, 4'b0000);
      check($sformatf("t038_stall_busy%0d", k), busy, 1'b1);
      tick();
    end
    full = 4'b0000;
    @(negedge clk);
    check("t038_push", push, 4'b0010);
    check("t038_dpush1", D_push[1], 16'h0199);
    tick();
    @(negedge clk);
    check("t038_idle", busy, 1'b0);
    tick();

    // Reset during a stall aborts the packet and rewinds the pointer
    send(2, 16'h0144, 4'b0010);
    @(negedge clk);
    check("t039_stall", push, 4'b0000);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    full  = 4'b0000;
    @(negedge clk);
    check("t039_busy", busy, 1'b0);
    check("t039_push", push, 4'b0000);
    check("t039_pop", pop, 4'b0000);
    check("t039_dpush", D_push[0], 16'h0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("t039_nopush%0d", k), push, 4'b0000);
    end
    tick();
    D_pop[0] = 16'h0322;
    D_pop[3] = 16'h0122;
    pndng    = 4'b1001;
    @(negedge clk);
    @(negedge clk);
    check("t039_rr_from0", pop, 4'b0001);
    tick();
    pndng = 4'b0000;
    wait_idle();
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
